// File: rtl/dk8e_rtc_pkg.sv
// Shared constants and IOT decode helper for the DK8E real-time clock.
// State and opcode encodings mirror parameters.v so the device drops in beside serial_top.
package dk8e_rtc_pkg;

   localparam logic [4:0] ST_F1    = 5'd1;
   localparam logic [2:0] IOT_OP   = 3'o6;
   localparam logic [5:0] DK8E_DEV = 6'o13;

   typedef enum logic [2:0] {
      FN_NOP0 = 3'o0,
      FN_CLEI = 3'o1,
      FN_CLDI = 3'o2,
      FN_CLSK = 3'o3,
      FN_CLRD = 3'o4,
      FN_CLZE = 3'o5,
      FN_CLLD = 3'o6,
      FN_NOP7 = 3'o7
   } rtc_func_e;

   typedef struct packed {
      logic      hit;
      rtc_func_e func;
   } rtc_iot_t;

   // User mode suppresses the IOT entirely; mem_ext raises the UI trap instead.
   function automatic rtc_iot_t decode_iot(input logic [4:0]  state,
                                           input logic [0:11] instr,
                                           input logic        uf,
                                           input logic [5:0]  dev);
      rtc_iot_t d;
      d.hit  = (state == ST_F1) && (instr[0:2] == IOT_OP) && (instr[3:8] == dev) && !uf;
      d.func = rtc_func_e'(instr[9:11]);
      return d;
   endfunction

endpackage

// File: rtl/dk8e_rtc_prescaler.sv
// Free-running divide-by-DIV counter producing a one-cycle tick on the last count.
module dk8e_rtc_prescaler
   import dk8e_rtc_pkg::*;
#(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   if (DIV < 2) begin : g_div_check
      $error("dk8e_rtc_prescaler: DIV must be at least 2");
   end

   localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] prescale;

   assign tick = (prescale == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prescale <= '0;
      else if (clr || tick)
         prescale <= '0;
      else
         prescale <= prescale + CNT_W'(1);
   end

endmodule

// File: rtl/dk8e_rtc.sv
// DK8E-style real-time clock, IOT device 13: tick flag, interrupt enable and a
// software-readable 12-bit tick counter feeding imux (skip/data) and the irq OR.
module dk8e_rtc
   import dk8e_rtc_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100000000,
   parameter int unsigned TICK_HZ = 60,
   parameter logic [5:0]  DEV     = DK8E_DEV
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [4:0]  state,
   input  logic [0:11] instruction,
   input  logic        UF,
   input  logic [0:11] ac,
   output logic [0:11] clk_bus,
   output logic        skip,
   output logic        interrupt
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;

   rtc_iot_t    iot;
   logic        tick;
   logic        do_clei, do_cldi, do_clsk, do_clrd, do_clze, do_clld;
   logic [0:11] tick_cnt;
   logic        flag;
   logic        ie;

   always_comb begin
      iot     = decode_iot(state, instruction, UF, DEV);
      do_clei = iot.hit && (iot.func == FN_CLEI);
      do_cldi = iot.hit && (iot.func == FN_CLDI);
      do_clsk = iot.hit && (iot.func == FN_CLSK);
      do_clrd = iot.hit && (iot.func == FN_CLRD);
      do_clze = iot.hit && (iot.func == FN_CLZE);
      do_clld = iot.hit && (iot.func == FN_CLLD);
   end

   dk8e_rtc_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (clear || do_clze),
      .tick  (tick)
   );

   // Skip reflects the pre-edge flag, so a tick landing on CLSK still reads 0.
   assign skip      = do_clsk && flag;
   assign interrupt = flag && ie;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag <= 1'b0;
         ie   <= 1'b0;
      end else if (clear) begin
         flag <= 1'b0;
         ie   <= 1'b0;
      end else begin
         if (tick)
            flag <= 1'b1;
         else if (do_clsk)
            flag <= 1'b0;

         if (do_clei)
            ie <= 1'b1;
         else if (do_cldi)
            ie <= 1'b0;
      end
   end

   // Software writes (CLZE/CLLD) take priority over a coincident tick increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (clear || do_clze)
         tick_cnt <= '0;
      else if (do_clld)
         tick_cnt <= ac;
      else if (tick)
         tick_cnt <= tick_cnt + 12'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         clk_bus <= '0;
      else if (clear)
         clk_bus <= '0;
      else if (do_clrd)
         clk_bus <= tick_cnt;
   end

endmodule

// File: tb/tb_dk8e_rtc.sv
// Directed plus randomized check of dk8e_rtc (DIV=10) against a cycle-level behavioural model.
module tb_dk8e_rtc;
   import dk8e_rtc_pkg::*;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [4:0]  state;
   logic [0:11] instruction;
   logic        UF;
   logic [0:11] ac;
   logic [0:11] clk_bus;
   logic        skip;
   logic        interrupt;

   int cmp  = 0;
   int errs = 0;

   // Behavioural model: m_since counts clocks since the prescaler last restarted.
   bit m_flag, m_ie;
   int m_cnt, m_bus, m_since, m_ticks;
   logic last_skip;

   dk8e_rtc #(
      .CLK_HZ  (100),
      .TICK_HZ (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .state       (state),
      .instruction (instruction),
      .UF          (UF),
      .ac          (ac),
      .clk_bus     (clk_bus),
      .skip        (skip),
      .interrupt   (interrupt)
   );

   always #5 clk = ~clk;

   function automatic bit tick_now();
      return (m_since % DIV) == DIV - 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      m_flag = 0; m_ie = 0; m_cnt = 0; m_bus = 0; m_since = 0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ":clk_bus"},   32'(clk_bus),      32'(m_bus));
      chk({tag, ":interrupt"}, 32'(interrupt),    32'(m_flag && m_ie));
      chk({tag, ":tick_cnt"},  32'(dut.tick_cnt), 32'(m_cnt));
      chk({tag, ":flag"},      32'(dut.flag),     32'(m_flag));
      chk({tag, ":ie"},        32'(dut.ie),       32'(m_ie));
   endtask

   // One clock: drive inputs, check combinational outputs, take the edge, update model, check state.
   task automatic step(input int instr, input int st, input bit uf, input int acv, input bit clr);
      bit hit, t;
      int fn, old_cnt;
      instruction = 12'(instr);
      state       = 5'(st);
      UF          = uf;
      ac          = 12'(acv);
      clear       = clr;
      hit = (st == int'(ST_F1)) && ((instr >> 9) == 6) && (((instr >> 3) & 63) == 'o13) && !uf;
      fn  = instr & 7;
      #1;
      last_skip = skip;
      chk("skip", 32'(skip), 32'(hit && fn == 3 && m_flag));
      chk("irq_pre", 32'(interrupt), 32'(m_flag && m_ie));
      @(posedge clk);
      if (clr) begin
         model_zero();
      end else begin
         t = tick_now();
         old_cnt = m_cnt;
         if (hit && fn == 1) m_ie = 1;
         if (hit && fn == 2) m_ie = 0;
         if (hit && fn == 4) m_bus = old_cnt;
         if (t) m_flag = 1;
         else if (hit && fn == 3) m_flag = 0;
         if (hit && fn == 5) begin
            m_cnt = 0;
            m_since = 0;
         end else begin
            if (hit && fn == 6) m_cnt = acv & 'o7777;
            else if (t) m_cnt = (m_cnt + 1) % 4096;
            m_since++;
         end
         if (t) m_ticks++;
      end
      #1;
      check_regs("edge");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('o7000, 0, 0, 0, 0);
   endtask

   task automatic wait_tick_now();
      int guard = 0;
      while (!tick_now() && guard < 2 * DIV) begin
         idle(1);
         guard++;
      end
      if (!tick_now()) chk("wait_tick_bound", 32'(guard), 32'(0));
   endtask

   task automatic async_reset();
      instruction = 12'o7000; state = '0; UF = 0; ac = '0; clear = 0;
      #2 reset = 1'b1;
      #1;
      model_zero();
      chk("rst:clk_bus",   32'(clk_bus),      32'(0));
      chk("rst:skip",      32'(skip),         32'(0));
      chk("rst:interrupt", 32'(interrupt),    32'(0));
      chk("rst:tick_cnt",  32'(dut.tick_cnt), 32'(0));
      chk("rst:flag",      32'(dut.flag),     32'(0));
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int base, guard, fn, dev, op, st;
      bit uf, clr;
      reset = 1'b0;
      m_ticks = 0;
      model_zero();
      async_reset();

      // 1: idle after reset -> three ticks, flag up, interrupt still disabled
      idle(35);
      chk("p1:tick_cnt", 32'(dut.tick_cnt), 32'(3));
      chk("p1:flag",     32'(dut.flag),     32'(1));
      chk("p1:irq",      32'(interrupt),    32'(0));

      // 2: enable, then acknowledge twice
      step('o6131, ST_F1, 0, 0, 0);
      chk("p2:irq_on", 32'(interrupt), 32'(1));
      step('o6133, ST_F1, 0, 0, 0);
      chk("p2:clsk1_skip", 32'(last_skip), 32'(1));
      chk("p2:irq_off",    32'(interrupt), 32'(0));
      step('o6133, ST_F1, 0, 0, 0);
      chk("p2:clsk2_skip", 32'(last_skip), 32'(0));

      // 3: load 7776, wrap through 7777 -> 0000 -> 0001, read back
      step('o6136, ST_F1, 0, 'o7776, 0);
      base = m_ticks;
      guard = 0;
      while (m_ticks < base + 3 && guard < 4 * DIV) begin
         idle(1);
         guard++;
      end
      chk("p3:tick_bound", 32'(m_ticks - base), 32'(3));
      step('o6134, ST_F1, 0, 0, 0);
      chk("p3:clk_bus", 32'(clk_bus), 32'(1));

      // 4: CLSK exactly on the tick cycle with flag clear; CLZE on a tick
      wait_tick_now();
      idle(1);
      step('o6133, ST_F1, 0, 0, 0);
      wait_tick_now();
      step('o6133, ST_F1, 0, 0, 0);
      chk("p4:clsk_tick_skip", 32'(last_skip), 32'(0));
      chk("p4:clsk_tick_flag", 32'(dut.flag),  32'(1));
      wait_tick_now();
      step('o6135, ST_F1, 0, 0, 0);
      chk("p4:clze_tick_cnt", 32'(dut.tick_cnt), 32'(0));

      // 5: user mode and foreign device are ignored
      step('o6132, ST_F1, 0, 0, 0);
      step('o6131, ST_F1, 1, 0, 0);
      step('o6133, ST_F1, 1, 0, 0);
      step('o6136, ST_F1, 1, 'o1234, 0);
      step('o6031, ST_F1, 0, 0, 0);
      chk("p5:ie", 32'(dut.ie), 32'(0));

      // 6: async reset at prescale=5, then a synchronous clear; first tick DIV cycles later
      guard = 0;
      while ((m_since % DIV) != 5 && guard < 2 * DIV) begin
         idle(1);
         guard++;
      end
      chk("p6:phase5", 32'(m_since % DIV), 32'(5));
      async_reset();
      idle(DIV - 1);
      chk("p6:rst_flag_before", 32'(dut.flag), 32'(0));
      idle(1);
      chk("p6:rst_flag_tick", 32'(dut.flag), 32'(1));
      idle(3);
      step('o6131, ST_F1, 0, 0, 1);
      idle(DIV - 1);
      chk("p6:clr_flag_before", 32'(dut.flag), 32'(0));
      idle(1);
      chk("p6:clr_flag_tick", 32'(dut.flag), 32'(1));

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         fn  = $urandom_range(0, 7);
         dev = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : 'o13;
         op  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 6;
         st  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : int'(ST_F1);
         uf  = ($urandom_range(0, 9) == 0);
         clr = ($urandom_range(0, 49) == 0);
         step((op << 9) | (dev << 3) | fn, st, uf, $urandom_range(0, 4095), clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
